pal_cfg_loader: RTL and testbench

//  Configuration sequencer for the PAL fabric: accepts the bitstream as bytes over a valid/ready

---
 rtl/pal_cfg_loader_pkg.sv | 22 ++
 rtl/pal_cfg_loader_clkgen.sv | 25 ++
 rtl/pal_cfg_loader.sv | 120 ++++++++++++
 tb/tb_pal_cfg_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pal_cfg_loader_pkg.sv
// pal_pkg: shared configuration-size derivation and loader FSM state encoding
package pal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic int cfg_bits(input int n, input int p, input int m);
        return 2 * n * p + p * m;
    endfunction

    function automatic int nbytes(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/pal_cfg_loader_clkgen.sv
// pal_cfg_clkgen: counts HALF_DIV clk cycles per cfg-clock phase and emits a tick at the end of each
module pal_cfg_clkgen #(
    parameter int HALF_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic tick_o
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick_o = run_i && (cnt_q == CW'(HALF_DIV - 1));

    // phase counter restarts whenever shifting pauses or a phase completes
    always_ff @(posedge clk) begin
        if (rst || !run_i || tick_o)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CW'(1);
    end

endmodule

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: streams a byte bitstream MSB-first onto the PAL cfg pins and verifies an XOR-8 checksum
module pal_cfg_loader
    import pal_pkg::*;
#(
    parameter int N        = 8,
    parameter int P        = 11,
    parameter int M        = 6,
    parameter int HALF_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       pal_cfg_bit,
    output logic       pal_cfg_clk,
    output logic       pal_cfg_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CFG_BITS = cfg_bits(N, P, M);
    localparam int BW       = $clog2(CFG_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);

    state_t        state_q, state_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    acc_q, acc_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          run;
    logic          tick;
    logic          rest;

    assign run  = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
    assign rest = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);

    pal_cfg_clkgen #(.HALF_DIV(HALF_DIV)) u_clkgen (
        .clk    (clk),
        .rst    (rst),
        .run_i  (run),
        .tick_o (tick)
    );

    // Moore outputs; the enable stays up across inter-byte fetches once the first bit has gone out
    assign s_ready     = (state_q == ST_FETCH) || (state_q == ST_CSUM);
    assign pal_cfg_clk = (state_q == ST_SHIFT_HI);
    assign pal_cfg_bit = run && sh_q[7];
    assign pal_cfg_en  = run || ((state_q == ST_FETCH) && (bit_q != '0));
    assign busy        = !rest;
    assign done        = (state_q == ST_DONE);
    assign err         = (state_q == ST_ERR);

    // next-state: byte fetch, two-phase bit shifting, checksum compare; abort overrides everything
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        bit_d   = bit_q;
        if (abort) begin
            state_d = ST_IDLE;
            sh_d    = '0;
            acc_d   = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_d = ST_FETCH;
                        sh_d    = '0;
                        acc_d   = '0;
                        bit_d   = '0;
                    end
                end
                ST_FETCH: begin
                    if (s_valid) begin
                        state_d = ST_SHIFT_LO;
                        sh_d    = s_data;
                        acc_d   = acc_q ^ s_data;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick)
                        state_d = ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        sh_d    = {sh_q[6:0], 1'b0};
                        bit_d   = (bit_q == LAST_BIT) ? bit_q : bit_q + BW'(1);
                        state_d = (bit_q == LAST_BIT)    ? ST_CSUM  :
                                  (bit_q[2:0] == 3'd7)   ? ST_FETCH : ST_SHIFT_LO;
                    end
                end
                ST_CSUM: begin
                    if (s_valid)
                        state_d = (s_data == acc_q) ? ST_DONE : ST_ERR;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb_pal_cfg_loader: table-driven loads plus abort/restart sequences against HALF_DIV=1 and HALF_DIV=3 instances
module tb_pal_cfg_loader;

    localparam int CFG_BITS = 242;
    localparam int NBYTES   = 31;

    typedef struct {
        int         h;
        logic [7:0] flip;
        int         stall_byte;
        int         start_byte;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    logic       clk = 0, rst = 1, start = 0, abort = 0, s_valid = 0, sel = 0, mon_clr = 1;
    logic [7:0] s_data = 0;
    logic       r1, b1, c1, e1, y1, d1, x1;
    logic       r3, b3, c3, e3, y3, d3, x3;
    logic       s_ready, pal_cfg_bit, pal_cfg_clk, pal_cfg_en, busy, done, err;
    logic [7:0] data [NBYTES];
    int         n_checks = 0, n_fail = 0;
    int         rises, bit_errs, stab_errs, phase_errs, en_errs, hi_len, lo_len, hd;
    logic       prev_clk, held_bit;

    assign s_ready     = sel ? r3 : r1;
    assign pal_cfg_bit = sel ? b3 : b1;
    assign pal_cfg_clk = sel ? c3 : c1;
    assign pal_cfg_en  = sel ? e3 : e1;
    assign busy        = sel ? y3 : y1;
    assign done        = sel ? d3 : d1;
    assign err         = sel ? x3 : x1;
    assign hd          = sel ? 3 : 1;

    pal_cfg_loader #(.HALF_DIV(1)) u1 (
        .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
        .s_data(s_data), .s_valid(s_valid & ~sel), .s_ready(r1),
        .pal_cfg_bit(b1), .pal_cfg_clk(c1), .pal_cfg_en(e1),
        .busy(y1), .done(d1), .err(x1)
    );

    pal_cfg_loader #(.HALF_DIV(3)) u3 (
        .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
        .s_data(s_data), .s_valid(s_valid & sel), .s_ready(r3),
        .pal_cfg_bit(b3), .pal_cfg_clk(c3), .pal_cfg_en(e3),
        .busy(y3), .done(d3), .err(x3)
    );

    always #5 clk = ~clk;

    function automatic logic exp_bit(input int k);
        logic [7:0] b;
        b = data[k / 8];
        return b[7 - (k % 8)];
    endfunction

    // fabric-side monitor: counts cfg_clk rises, checks bit order, bit stability and phase lengths
    always @(negedge clk) begin
        if (mon_clr) begin
            rises <= 0; bit_errs <= 0; stab_errs <= 0; phase_errs <= 0; en_errs <= 0;
            hi_len <= 0; lo_len <= 0; prev_clk <= 0; held_bit <= 0;
        end else begin
            if (pal_cfg_clk && !pal_cfg_en) en_errs <= en_errs + 1;
            if (pal_cfg_clk && !prev_clk) begin
                if (rises > 0 && lo_len < hd) phase_errs <= phase_errs + 1;
                if (rises >= CFG_BITS || pal_cfg_bit !== exp_bit(rises)) bit_errs <= bit_errs + 1;
                held_bit <= pal_cfg_bit;
                rises    <= rises + 1;
                hi_len   <= 1;
            end else if (pal_cfg_clk) begin
                hi_len <= hi_len + 1;
                if (pal_cfg_bit !== held_bit) stab_errs <= stab_errs + 1;
            end
            if (!pal_cfg_clk && prev_clk && hi_len != hd) phase_errs <= phase_errs + 1;
            lo_len   <= pal_cfg_clk ? 0 : lo_len + 1;
            prev_clk <= pal_cfg_clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!s_ready && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got s_ready=0 expected 1 within 2000 cycles");
        end
    endtask

    task automatic send(input logic [7:0] b);
        s_data  = b;
        s_valid = 1;
        wait_ready();
        tick();
        s_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic clear_monitor();
        mon_clr = 1;
        tick();
        mon_clr = 0;
    endtask

    task automatic run_load(input vec_t v);
        logic [7:0] acc = 0;
        sel = (v.h == 3);
        clear_monitor();
        pulse_start();
        check("start_state_busy_done_err", {busy, done, err}, 3'b100);
        for (int i = 0; i < NBYTES; i++) begin
            if (i == v.stall_byte) begin
                wait_ready();
                repeat (5) tick();
                check("stall_clk_en_ready", {pal_cfg_clk, pal_cfg_en, s_ready}, 3'b011);
            end
            send(data[i]);
            acc ^= data[i];
            if (i == v.start_byte) begin
                tick();
                pulse_start();
                check("start_ignored_busy", {busy, s_ready}, 2'b10);
            end
        end
        send(acc ^ v.flip);
        check("done", done, v.exp_done);
        check("err", err, v.exp_err);
        check("idle_busy_en", {busy, pal_cfg_en, pal_cfg_clk}, 3'b000);
        check("cfg_clk_rises", rises, CFG_BITS);
        check("bit_order_errors", bit_errs, 0);
        check("bit_stability_errors", stab_errs, 0);
        check("phase_length_errors", phase_errs, 0);
        check("clk_without_en_errors", en_errs, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t vt [5];
        vec_t good;
        vt[0] = '{h: 1, flip: 8'h00, stall_byte: -1, start_byte: -1, exp_done: 1'b1, exp_err: 1'b0};
        vt[1] = '{h: 1, flip: 8'h01, stall_byte: -1, start_byte: -1, exp_done: 1'b0, exp_err: 1'b1};
        vt[2] = '{h: 1, flip: 8'h00, stall_byte: 12, start_byte: -1, exp_done: 1'b1, exp_err: 1'b0};
        vt[3] = '{h: 3, flip: 8'h00, stall_byte: -1, start_byte: -1, exp_done: 1'b1, exp_err: 1'b0};
        vt[4] = '{h: 1, flip: 8'h00, stall_byte: -1, start_byte: 5,  exp_done: 1'b1, exp_err: 1'b0};
        good  = vt[0];
        for (int i = 0; i < NBYTES; i++)
            data[i] = 8'((i * 29 + 7) ^ 8'h5A);

        repeat (3) tick();
        check("reset_outputs_u1",
              {r1, b1, c1, e1, y1, d1, x1}, 7'b0);
        check("reset_outputs_u3",
              {r3, b3, c3, e3, y3, d3, x3}, 7'b0);
        rst = 0;
        tick();

        for (int i = 0; i < 5; i++)
            run_load(vt[i]);

        sel = 0;
        clear_monitor();
        pulse_start();
        for (int i = 0; i <= 10; i++)
            send(data[i]);
        repeat (3) tick();
        check("pre_abort_shifting", {busy, pal_cfg_en}, 2'b11);
        abort = 1;
        start = 1;
        tick();
        abort = 0;
        start = 0;
        check("post_abort_idle",
              {s_ready, pal_cfg_bit, pal_cfg_clk, pal_cfg_en, busy, done, err}, 7'b0);
        run_load(good);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
